// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//   Execute stage of a 5-stage MIPS pipeline. Performs the ALU operation
//   selected by the ID/EX register and hosts a 32-iteration shift-add
//   unsigned multiplier that writes the HI/LO registers. All state updates
//   happen on the falling edge of clk, matching the pipeline registers.
//
// Ports
//   clk            : pipeline clock (state updates on falling edge)
//   rst            : synchronous active-high reset, sampled on falling edge
//   Rs_data_in     : first operand
//   Rt_data_in     : second operand / shift source
//   ALU_op_in      : 00 add, 01 sub, 10 R-type (decode funct), 11 reserved
//   Funct_ctrl_in  : R-type function code
//   shamt_in       : shift amount
//   Rd_addr_in     : destination register
//   Reg_w_in       : register-write request
//   stall          : high while the multiplier is busy (combinational)
//   ALU_result_out : registered result
//   Rd_addr_out    : registered destination
//   Reg_w_out      : registered write enable
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int DATA_W   = 32,
    parameter int MUL_ITER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Rs_data_in,
    input  logic [DATA_W-1:0] Rt_data_in,
    input  logic [1:0]        ALU_op_in,
    input  logic [5:0]        Funct_ctrl_in,
    input  logic [4:0]        shamt_in,
    input  logic [4:0]        Rd_addr_in,
    input  logic              Reg_w_in,
    output logic              stall,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [4:0]        Rd_addr_out,
    output logic              Reg_w_out
);

    localparam int CNT_W = $clog2(MUL_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   alu_result_q, alu_result_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic                reg_w_q, reg_w_d;

    logic [DATA_W-1:0]   alu_val_s;
    logic                alu_valid_s;
    logic                is_multu_s;
    logic                slt_s;
    logic [2*DATA_W-1:0] acc_sum_s;

    assign slt_s = ($signed(Rs_data_in) < $signed(Rt_data_in));

    // Accumulator plus the current partial product (added only when the
    // multiplier LSB is set); this is also the final product on the last edge.
    assign acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*DATA_W){1'b0}});

    // ALU operation decode; alu_valid_s low means the op must not write a GPR.
    always_comb begin
        alu_val_s   = {DATA_W{1'b0}};
        alu_valid_s = 1'b0;
        is_multu_s  = 1'b0;
        case (ALU_op_in)
            2'b00: begin
                alu_val_s   = Rs_data_in + Rt_data_in;
                alu_valid_s = 1'b1;
            end
            2'b01: begin
                alu_val_s   = Rs_data_in - Rt_data_in;
                alu_valid_s = 1'b1;
            end
            2'b10: begin
                alu_valid_s = 1'b1;
                case (Funct_ctrl_in)
                    FN_ADD:   alu_val_s = Rs_data_in + Rt_data_in;
                    FN_SUB:   alu_val_s = Rs_data_in - Rt_data_in;
                    FN_AND:   alu_val_s = Rs_data_in & Rt_data_in;
                    FN_OR:    alu_val_s = Rs_data_in | Rt_data_in;
                    FN_SLT:   alu_val_s = {{(DATA_W-1){1'b0}}, slt_s};
                    FN_SLL:   alu_val_s = Rt_data_in << shamt_in;
                    FN_SRL:   alu_val_s = Rt_data_in >> shamt_in;
                    FN_MFHI:  alu_val_s = hi_q;
                    FN_MFLO:  alu_val_s = lo_q;
                    FN_MULTU: begin
                        // multu only loads the multiplier; it never writes a GPR.
                        alu_valid_s = 1'b0;
                        is_multu_s  = 1'b1;
                    end
                    default:  alu_valid_s = 1'b0;
                endcase
            end
            default: alu_valid_s = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE/MUL controller, multiplier datapath and output registers.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        alu_result_d = alu_result_q;
        rd_addr_d    = rd_addr_q;
        reg_w_d      = reg_w_q;
        case (state_q)
            ST_IDLE: begin
                rd_addr_d    = Rd_addr_in;
                alu_result_d = alu_valid_s ? alu_val_s : {DATA_W{1'b0}};
                reg_w_d      = Reg_w_in & alu_valid_s;
                if (is_multu_s) begin
                    mcand_d  = {{DATA_W{1'b0}}, Rt_data_in};
                    mplier_d = Rs_data_in;
                    acc_d    = {(2*DATA_W){1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_MUL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MUL: begin
                // Pipeline sees bubbles while the multiplier runs.
                alu_result_d = {DATA_W{1'b0}};
                reg_w_d      = 1'b0;
                acc_d        = acc_sum_s;
                mcand_d      = mcand_q << 1;
                mplier_d     = mplier_q >> 1;
                cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    {hi_d, lo_d} = acc_sum_s;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_MUL;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                alu_result_d = {DATA_W{1'b0}};
                reg_w_d      = 1'b0;
            end
        endcase
    end

    // State registers, updated on the falling edge with synchronous reset priority.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hi_q         <= {DATA_W{1'b0}};
            lo_q         <= {DATA_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            mcand_q      <= {(2*DATA_W){1'b0}};
            mplier_q     <= {DATA_W{1'b0}};
            acc_q        <= {(2*DATA_W){1'b0}};
            alu_result_q <= {DATA_W{1'b0}};
            rd_addr_q    <= 5'd0;
            reg_w_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            alu_result_q <= alu_result_d;
            rd_addr_q    <= rd_addr_d;
            reg_w_q      <= reg_w_d;
        end
    end

    assign stall          = (state_q == ST_MUL);
    assign ALU_result_out = alu_result_q;
    assign Rd_addr_out    = rd_addr_q;
    assign Reg_w_out      = reg_w_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
//   Directed testbench for ex_stage. Inputs are driven 1 time unit after the
//   falling (active) edge; outputs are sampled at the same point, away from
//   the edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [31:0] rs_s;
    logic [31:0] rt_s;
    logic [1:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  shamt_s;
    logic [4:0]  rd_s;
    logic        regw_s;
    logic        stall_s;
    logic [31:0] result_s;
    logic [4:0]  rd_out_s;
    logic        regw_out_s;

    int checks_r;
    int errors_r;

    ex_stage #(.DATA_W(32), .MUL_ITER(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .Rs_data_in     (rs_s),
        .Rt_data_in     (rt_s),
        .ALU_op_in      (op_s),
        .Funct_ctrl_in  (funct_s),
        .shamt_in       (shamt_s),
        .Rd_addr_in     (rd_s),
        .Reg_w_in       (regw_s),
        .stall          (stall_s),
        .ALU_result_out (result_s),
        .Rd_addr_out    (rd_out_s),
        .Reg_w_out      (regw_out_s)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] sh, input logic [4:0] rd,
                         input logic rw);
        op_s    = op;
        funct_s = fn;
        rs_s    = rs;
        rt_s    = rt;
        shamt_s = sh;
        rd_s    = rd;
        regw_s  = rw;
    endtask

    // Ticks until stall drops; an exhausted budget counts as a failure.
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (stall_s === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (stall_s !== 1'b0) check_eq("stall_timeout", 32'(stall_s), 32'd0);
    endtask

    initial begin
        int stall_cnt;
        int bad_wr;
        checks_r = 0;
        errors_r = 0;
        rst = 1'b1;
        drive(2'b00, 6'h00, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        #1;
        tick();
        tick();
        check_eq("rst_result", result_s, 32'd0);
        check_eq("rst_rd", 32'(rd_out_s), 32'd0);
        check_eq("rst_regw", 32'(regw_out_s), 32'd0);
        check_eq("rst_stall", 32'(stall_s), 32'd0);
        rst = 1'b0;

        // R-type add with wraparound into the sign bit
        drive(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd5, 1'b1);
        tick();
        check_eq("add_result", result_s, 32'h8000_0000);
        check_eq("add_rd", 32'(rd_out_s), 32'd5);
        check_eq("add_regw", 32'(regw_out_s), 32'd1);

        drive(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd6, 1'b1);
        tick();
        check_eq("slt_neg", result_s, 32'd1);

        drive(2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF, 5'd0, 5'd6, 1'b1);
        tick();
        check_eq("slt_pos", result_s, 32'd0);

        drive(2'b10, 6'h00, 32'd0, 32'd1, 5'd31, 5'd7, 1'b1);
        tick();
        check_eq("sll31", result_s, 32'h8000_0000);

        drive(2'b10, 6'h02, 32'd0, 32'h8000_0000, 5'd4, 5'd7, 1'b1);
        tick();
        check_eq("srl4", result_s, 32'h0800_0000);

        drive(2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 5'd3, 1'b1);
        tick();
        check_eq("and", result_s, 32'hF000_F000);

        drive(2'b10, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 5'd3, 1'b1);
        tick();
        check_eq("or", result_s, 32'hFFF0_FFF0);

        drive(2'b01, 6'h00, 32'd5, 32'd7, 5'd0, 5'd4, 1'b1);
        tick();
        check_eq("op01_sub", result_s, 32'hFFFF_FFFE);

        drive(2'b00, 6'h3F, 32'h1234_0000, 32'h0000_5678, 5'd0, 5'd4, 1'b1);
        tick();
        check_eq("op00_add", result_s, 32'h1234_5678);

        // Reserved ALU op and unknown funct must not write
        drive(2'b11, 6'h20, 32'd9, 32'd9, 5'd0, 5'd9, 1'b1);
        tick();
        check_eq("op11_result", result_s, 32'd0);
        check_eq("op11_regw", 32'(regw_out_s), 32'd0);

        drive(2'b10, 6'h3F, 32'd9, 32'd9, 5'd0, 5'd9, 1'b1);
        tick();
        check_eq("badfn_result", result_s, 32'd0);
        check_eq("badfn_regw", 32'(regw_out_s), 32'd0);

        // multu 7*6, then a held mflo
        drive(2'b10, 6'h19, 32'd7, 32'd6, 5'd0, 5'd10, 1'b1);
        tick();
        check_eq("multu_stall", 32'(stall_s), 32'd1);
        check_eq("multu_regw", 32'(regw_out_s), 32'd0);
        check_eq("multu_result", result_s, 32'd0);
        check_eq("multu_rd", 32'(rd_out_s), 32'd10);
        drive(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, 5'd8, 1'b1);
        stall_cnt = 1;
        bad_wr    = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall_s === 1'b1) begin
                tick();
                if (stall_s === 1'b1) stall_cnt++;
                if (regw_out_s !== 1'b0 || result_s !== 32'd0) bad_wr++;
            end
        end
        check_eq("mul_stall_cycles", 32'(stall_cnt), 32'd32);
        check_eq("mul_bubbles", 32'(bad_wr), 32'd0);
        tick();
        check_eq("mflo_42", result_s, 32'd42);
        check_eq("mflo_regw", 32'(regw_out_s), 32'd1);
        check_eq("mflo_rd", 32'(rd_out_s), 32'd8);
        drive(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 5'd8, 1'b1);
        tick();
        check_eq("mfhi_0", result_s, 32'd0);

        // Corner multiply: 0xFFFFFFFF squared
        drive(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd11, 1'b1);
        tick();
        drive(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 5'd12, 1'b1);
        wait_idle(40);
        tick();
        check_eq("corner_hi", result_s, 32'hFFFF_FFFE);
        drive(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, 5'd12, 1'b1);
        tick();
        check_eq("corner_lo", result_s, 32'h0000_0001);

        // Reset in the middle of a multiply: no partial product may land in HI/LO
        drive(2'b10, 6'h19, 32'd3, 32'd5, 5'd0, 5'd13, 1'b1);
        tick();
        drive(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, 5'd14, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        check_eq("mid_mul_stall", 32'(stall_s), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("abort_stall", 32'(stall_s), 32'd0);
        check_eq("abort_result", result_s, 32'd0);
        check_eq("abort_regw", 32'(regw_out_s), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("abort_lo", result_s, 32'd0);
        drive(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 5'd14, 1'b1);
        tick();
        check_eq("abort_hi", result_s, 32'd0);
        check_eq("abort_hi_regw", 32'(regw_out_s), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
